// File: rtl/lsu_md.sv
// -----------------------------------------------------------------------------
// lsu_md : load/store unit with sub-word support for a single-ported
// word-addressed memory.
//
// Loads read one word and return the extracted byte/half/word, sign- or
// zero-extended. Word stores write straight through. Byte and half stores are
// done as read-modify-write: read the word, replace one lane, write it back.
// Only one request is in flight. A new request can be accepted in the same
// cycle that the previous response is presented.
//
// Configuration macro: LSU_MISALIGN_CHK_EN
//   defined   : a misaligned half or word access completes through ERR with
//               rsp_err=1 and never touches memory.
//   undefined : misaligned addresses are silently aligned down, ERR is
//               unreachable, and rsp_err is tied to 0.
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   req_valid/req_ready request handshake; ready only while idle
//   req_we              1 = store, 0 = load
//   req_addr            byte address
//   req_size            00 byte, 01 half, 10/11 word
//   req_unsigned        loads: zero-extend when 1, sign-extend when 0
//   req_wdata           store data, right-aligned
//   rsp_valid           one-cycle completion pulse (no backpressure)
//   rsp_rdata           extended load data, 0 for stores and errors
//   rsp_err             misaligned-access flag, qualified by rsp_valid
//   mem_ren/mem_raddr   memory read strobe / word address
//   mem_wen/mem_waddr   memory write strobe / word address
//   mem_wdata           memory write word
//   mem_rdata           memory read data, valid the cycle after mem_ren
// -----------------------------------------------------------------------------
module lsu_md #(
    parameter int WIDTH      = 32,
    parameter int WIDTH_BITS = 30
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [WIDTH-1:0]      req_wdata,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_ren,
    output logic [WIDTH_BITS-1:0] mem_raddr,
    output logic                  mem_wen,
    output logic [WIDTH_BITS-1:0] mem_waddr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_REQ   = 3'd1,
        LD_WAIT  = 3'd2,
        ST_RD    = 3'd3,
        ST_MERGE = 3'd4,
        ST_WR    = 3'd5,
        ERR      = 3'd6
    } state_t;

    state_t           state_r;
    logic             we_r;
    logic [31:0]      addr_r;
    logic [1:0]       size_r;
    logic             uns_r;
    logic [WIDTH-1:0] wdata_r;

    logic [31:0]      addr_al_s;
    logic             misalign_s;

    // Pick the addressed lane out of a memory word and extend it to WIDTH.
    function automatic logic [WIDTH-1:0] load_extend(
        input logic [WIDTH-1:0] word,
        input logic [1:0]       off,
        input logic [1:0]       size,
        input logic             uns
    );
        logic [7:0]       b;
        logic [15:0]      h;
        logic [WIDTH-1:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = {{(WIDTH-8){~uns & b[7]}}, b};
            2'b01:   r = {{(WIDTH-16){~uns & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace only the addressed lane of the old word with the low store bits.
    function automatic logic [WIDTH-1:0] store_merge(
        input logic [WIDTH-1:0] old,
        input logic [WIDTH-1:0] wd,
        input logic [1:0]       off,
        input logic [1:0]       size
    );
        logic [WIDTH-1:0] r;
        r = old;
        case (size)
            2'b00: begin
                case (off)
                    2'd0:    r[7:0]   = wd[7:0];
                    2'd1:    r[15:8]  = wd[7:0];
                    2'd2:    r[23:16] = wd[7:0];
                    default: r[31:24] = wd[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) begin
                    r[31:16] = wd[15:0];
                end else begin
                    r[15:0] = wd[15:0];
                end
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    // Alignment of the incoming address and misalignment detection.
    always_comb begin
        misalign_s = 1'b0;
        addr_al_s  = req_addr;
        case (req_size)
            2'b00: addr_al_s = req_addr;
            2'b01: begin
                addr_al_s = {req_addr[31:1], 1'b0};
`ifdef LSU_MISALIGN_CHK_EN
                misalign_s = req_addr[0];
`endif
            end
            default: begin
                addr_al_s = {req_addr[31:2], 2'b00};
`ifdef LSU_MISALIGN_CHK_EN
                misalign_s = (req_addr[1:0] != 2'b00);
`endif
            end
        endcase
    end

    // Control FSM, request capture and registered response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            we_r      <= 1'b0;
            addr_r    <= 32'h0000_0000;
            size_r    <= 2'b00;
            uns_r     <= 1'b0;
            wdata_r   <= {WIDTH{1'b0}};
            rsp_valid <= 1'b0;
            rsp_rdata <= {WIDTH{1'b0}};
`ifdef LSU_MISALIGN_CHK_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            // Response is a single-cycle pulse unless a branch below raises it.
            rsp_valid <= 1'b0;
            rsp_rdata <= {WIDTH{1'b0}};
`ifdef LSU_MISALIGN_CHK_EN
            rsp_err   <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        we_r    <= req_we;
                        addr_r  <= addr_al_s;
                        size_r  <= req_size;
                        uns_r   <= req_unsigned;
                        wdata_r <= req_wdata;
                        if (misalign_s) begin
                            // The error response shows up in the ERR cycle.
                            state_r   <= ERR;
                            rsp_valid <= 1'b1;
`ifdef LSU_MISALIGN_CHK_EN
                            rsp_err   <= 1'b1;
`endif
                        end else if (!req_we) begin
                            state_r <= LD_REQ;
                        end else if (req_size[1]) begin
                            state_r <= ST_WR;
                        end else begin
                            state_r <= ST_RD;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LD_REQ:  state_r <= LD_WAIT;
                LD_WAIT: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= load_extend(mem_rdata, addr_r[1:0], size_r, uns_r);
                    state_r   <= IDLE;
                end
                ST_RD:   state_r <= ST_MERGE;
                ST_MERGE, ST_WR: begin
                    rsp_valid <= 1'b1;
                    state_r   <= IDLE;
                end
                ERR:     state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

`ifndef LSU_MISALIGN_CHK_EN
    assign rsp_err = 1'b0;
`endif

    // Memory strobes, addresses and write data decoded from the state register.
    always_comb begin
        req_ready = (state_r == IDLE);
        mem_ren   = (state_r == LD_REQ) || (state_r == ST_RD);
        mem_wen   = (state_r == ST_MERGE) || (state_r == ST_WR);
        if (state_r != IDLE) begin
            mem_raddr = WIDTH_BITS'(addr_r[31:2]);
            mem_waddr = WIDTH_BITS'(addr_r[31:2]);
        end else begin
            mem_raddr = {WIDTH_BITS{1'b0}};
            mem_waddr = {WIDTH_BITS{1'b0}};
        end
        case (state_r)
            ST_WR:    mem_wdata = wdata_r;
            ST_MERGE: mem_wdata = store_merge(mem_rdata, wdata_r, addr_r[1:0], size_r);
            default:  mem_wdata = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: tb/tb_lsu_md.sv
// -----------------------------------------------------------------------------
// tb_lsu_md : self-checking bench for lsu_md.
// A table of requests with expected responses is run back to back; each
// accepted request pushes its expected response onto a queue, popped when
// rsp_valid appears. Hand-written sequences cover the read-modify-write
// cycle detail, back-to-back accept and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_lsu_md;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_ren;
    logic [29:0] mem_raddr;
    logic        mem_wen;
    logic [29:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        tbl [19];
    logic [32:0] sb [$];

    logic [31:0] mem [0:63];
    logic        mem_init = 1'b1;

    lsu_md #(.WIDTH(32), .WIDTH_BITS(30)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle read latency, garbage when not reading.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h8899_AABB;
            mem[5] <= 32'h0123_4567;
        end else if (mem_wen) begin
            mem[mem_waddr[5:0]] <= mem_wdata;
        end
        mem_rdata <= mem_ren ? mem[mem_raddr[5:0]] : 32'h5A5A_5A5A;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        req_valid    = 1'b1;
        req_we       = v.we;
        req_addr     = v.addr;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_wdata    = v.wdata;
    endtask

    // Issue one request in the current cycle and follow it to its response.
    task automatic exec(input int idx, input vec_t v);
        int          lat;
        bit          got;
        bit          word;
        logic        exp_ren;
        logic        exp_wen;
        logic [32:0] e;
        word = v.size[1];
        lat  = v.exp_err ? 1 : ((v.we && word) ? 2 : 3);
        chk($sformatf("v%0d ready", idx), req_ready, 32'd1);
        drive(v);
        sb.push_back({v.exp_err, v.exp_rdata});
        tick();
        req_valid = 1'b0;
        got = 1'b0;
        for (int k = 1; k <= 6 && !got; k++) begin
            if (k <= lat) begin
                exp_ren = !v.exp_err && (k == 1) && !(v.we && word);
                exp_wen = !v.exp_err && v.we && ((word && k == 1) || (!word && k == 2));
                chk($sformatf("v%0d c%0d mem_ren", idx, k), mem_ren, exp_ren);
                chk($sformatf("v%0d c%0d mem_wen", idx, k), mem_wen, exp_wen);
                if (exp_ren) chk($sformatf("v%0d raddr", idx), mem_raddr, v.addr[31:2]);
                if (exp_wen) chk($sformatf("v%0d waddr", idx), mem_waddr, v.addr[31:2]);
                if (exp_wen && word) chk($sformatf("v%0d wdata", idx), mem_wdata, v.wdata);
            end
            if (rsp_valid) begin
                got = 1'b1;
                chk($sformatf("v%0d latency", idx), k, lat);
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL v%0d response: got rsp_valid expected none pending", idx);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("v%0d rdata", idx), rsp_rdata, e[31:0]);
                    chk($sformatf("v%0d err", idx), rsp_err, e[32]);
                end
            end else begin
                tick();
            end
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL v%0d timeout: got no rsp_valid expected one within 6 cycles", idx);
            sb.delete();
        end
        if (v.exp_err) tick();
    endtask

    initial begin
        logic        mis;
        vec_t        v;
`ifdef LSU_MISALIGN_CHK_EN
        mis = 1'b1;
`else
        mis = 1'b0;
`endif
        tbl[0]  = mk(1'b0, 32'h11, 2'b00, 1'b0, 32'h0, 32'hFFFF_FFAA, 1'b0);
        tbl[1]  = mk(1'b0, 32'h11, 2'b00, 1'b1, 32'h0, 32'h0000_00AA, 1'b0);
        tbl[2]  = mk(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 32'hFFFF_FF88, 1'b0);
        tbl[3]  = mk(1'b0, 32'h10, 2'b00, 1'b1, 32'h0, 32'h0000_00BB, 1'b0);
        tbl[4]  = mk(1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 32'hFFFF_8899, 1'b0);
        tbl[5]  = mk(1'b0, 32'h10, 2'b01, 1'b1, 32'h0, 32'h0000_AABB, 1'b0);
        tbl[6]  = mk(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h8899_AABB, 1'b0);
        tbl[7]  = mk(1'b0, 32'h10, 2'b11, 1'b0, 32'h0, 32'h8899_AABB, 1'b0);
        tbl[8]  = mk(1'b0, 32'h13, 2'b10, 1'b0, 32'h0, mis ? 32'h0 : 32'h8899_AABB, mis);
        tbl[9]  = mk(1'b0, 32'h11, 2'b01, 1'b0, 32'h0, mis ? 32'h0 : 32'hFFFF_AABB, mis);
        tbl[10] = mk(1'b1, 32'h15, 2'b00, 1'b0, 32'hFFFF_FF55, 32'h0, 1'b0);
        tbl[11] = mk(1'b0, 32'h14, 2'b10, 1'b0, 32'h0, 32'h0123_5567, 1'b0);
        tbl[12] = mk(1'b1, 32'h14, 2'b01, 1'b0, 32'h0000_CAFE, 32'h0, 1'b0);
        tbl[13] = mk(1'b1, 32'h17, 2'b01, 1'b0, 32'h0000_BEEF, 32'h0, mis);
        tbl[14] = mk(1'b0, 32'h14, 2'b10, 1'b0, 32'h0, mis ? 32'h0123_CAFE : 32'hBEEF_CAFE, 1'b0);
        tbl[15] = mk(1'b1, 32'h20, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);
        tbl[16] = mk(1'b0, 32'h22, 2'b01, 1'b0, 32'h0, 32'hFFFF_DEAD, 1'b0);
        tbl[17] = mk(1'b0, 32'h20, 2'b00, 1'b1, 32'h0, 32'h0000_00EF, 1'b0);
        tbl[18] = mk(1'b0, 32'h22, 2'b10, 1'b0, 32'h0, mis ? 32'h0 : 32'hDEAD_BEEF, mis);

        // Reset state.
        tick();
        tick();
        mem_init = 1'b0;
        chk("rst rsp_valid", rsp_valid, 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        chk("rst rsp_err", rsp_err, 32'd0);
        chk("rst mem_ren", mem_ren, 32'd0);
        chk("rst mem_wen", mem_wen, 32'd0);
        chk("rst mem_raddr", mem_raddr, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst req_ready", req_ready, 32'd1);

        // Table run, requests issued back to back.
        for (int i = 0; i < 19; i++) exec(i, tbl[i]);

        // Half store read-modify-write, cycle by cycle (word 4 = 0x8899AABB).
        tick();
        v = mk(1'b1, 32'h12, 2'b01, 1'b0, 32'h0000_1234, 32'h0, 1'b0);
        chk("hs ready", req_ready, 32'd1);
        drive(v);
        tick();
        req_valid = 1'b0;
        chk("hs c1 mem_ren", mem_ren, 32'd1);
        chk("hs c1 raddr", mem_raddr, 32'd4);
        chk("hs c1 mem_wen", mem_wen, 32'd0);
        tick();
        chk("hs c2 mem_wen", mem_wen, 32'd1);
        chk("hs c2 waddr", mem_waddr, 32'd4);
        chk("hs c2 wdata", mem_wdata, 32'h1234_AABB);
        chk("hs c2 mem_ren", mem_ren, 32'd0);
        tick();
        chk("hs c3 rsp_valid", rsp_valid, 32'd1);
        chk("hs c3 rsp_err", rsp_err, 32'd0);
        chk("hs c3 rsp_rdata", rsp_rdata, 32'd0);

        // Second request presented in C3 of the first: accepted, mem_ren in C4.
        chk("b2b c3 ready", req_ready, 32'd1);
        drive(mk(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0));
        tick();
        req_valid = 1'b0;
        chk("b2b c4 mem_ren", mem_ren, 32'd1);
        chk("b2b c4 raddr", mem_raddr, 32'd4);
        tick();
        tick();
        chk("b2b rsp_valid", rsp_valid, 32'd1);
        chk("b2b rsp_rdata", rsp_rdata, 32'h1234_AABB);

        // Reset during C1 of a byte store aborts it.
        tick();
        drive(mk(1'b1, 32'h14, 2'b00, 1'b0, 32'h0000_0077, 32'h0, 1'b0));
        tick();
        req_valid = 1'b0;
        chk("rs c1 mem_ren", mem_ren, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rs c2 mem_wen", mem_wen, 32'd0);
        chk("rs c2 rsp_valid", rsp_valid, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("rs post%0d ready", k), req_ready, 32'd1);
            chk($sformatf("rs post%0d mem_wen", k), mem_wen, 32'd0);
            chk($sformatf("rs post%0d rsp_valid", k), rsp_valid, 32'd0);
        end
        // The aborted store left word 5 untouched.
        exec(100, tbl[14]);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
